// File: rtl/relay_pkg.sv
// -----------------------------------------------------------------------------
// relay_pkg
// Shared definitions for the relay-mode datapath: controller mode codes,
// nibble width, packer FSM state encoding and frame marker nibbles.
// -----------------------------------------------------------------------------
package relay_pkg;

   // Controller mode codes (3-bit mod_type field)
   localparam logic [2:0] MOD_SNIFFER     = 3'd0;
   localparam logic [2:0] MOD_READER      = 3'd1;
   localparam logic [2:0] MOD_TAG         = 3'd2;
   localparam logic [2:0] MOD_FAKE_READER = 3'd3;
   localparam logic [2:0] MOD_FAKE_TAG    = 3'd4;

   localparam int NIBBLE_W = 4;

   // Packer FSM states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } packer_state_t;

   // Frame marker nibbles
   localparam logic [NIBBLE_W-1:0] NIB_READER_START = 4'hc;
   localparam logic [NIBBLE_W-1:0] NIB_TAG_START    = 4'hf;

endpackage

// File: rtl/relay_bit_integrator.sv
// -----------------------------------------------------------------------------
// relay_bit_integrator
// Counts high samples across one bit period of BIT_CLKS cycles and makes the
// majority decision on the last phase of the period.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : synchronous clear of phase/ones (has priority over i_count)
//   i_count      : this cycle belongs to a bit period; advance and count
//   i_sample     : synchronised input sample
//   o_bit_valid  : combinational, high in the last phase of a bit period
//   o_bit_value  : decided bit, valid with o_bit_valid
// -----------------------------------------------------------------------------
module relay_bit_integrator
   import relay_pkg::*;
#(
   parameter int BIT_CLKS = 16,
   parameter int THRESH   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_count,
   input  logic i_sample,
   output logic o_bit_valid,
   output logic o_bit_value
);

   localparam int PH_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
   localparam int ONES_W = $clog2(BIT_CLKS + 1);

   logic [PH_W-1:0]   r_phase;
   logic [ONES_W-1:0] r_ones;
   logic              w_last;
   logic [ONES_W:0]   w_total;

   assign w_last  = (r_phase == PH_W'(BIT_CLKS - 1));
   // The current sample is folded in so the decision covers all BIT_CLKS samples.
   assign w_total = {1'b0, r_ones} + (ONES_W + 1)'(i_sample);

   assign o_bit_valid = i_count & w_last;
   assign o_bit_value = (w_total >= (ONES_W + 1)'(THRESH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
         r_ones  <= '0;
      end else if (i_clr) begin
         r_phase <= '0;
         r_ones  <= '0;
      end else if (i_count) begin
         if (w_last) begin
            r_phase <= '0;
            r_ones  <= '0;
         end else begin
            r_phase <= r_phase + 1'b1;
            r_ones  <= w_total[ONES_W-1:0];
         end
      end
   end

endmodule

// File: rtl/relay_nibble_packer.sv
// -----------------------------------------------------------------------------
// relay_nibble_packer
// Synchronises the demodulated input, starts a frame on a rising edge, decodes
// bits by majority over fixed bit periods and packs them MSB-first into
// nibbles, strobing each completed nibble for one cycle. A frame ends after
// IDLE_NIBBLES consecutive zero nibbles.
// Ports:
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   enable         : controller is in a fake reader/tag mode
//   mod_in         : demodulated comparator output (asynchronous)
//   data_out       : last completed nibble, bit 3 = first-received bit
//   data_available : one-cycle strobe, data_out valid in the same cycle
//   active         : high while a frame is running
// -----------------------------------------------------------------------------
module relay_nibble_packer
   import relay_pkg::*;
#(
   parameter int BIT_CLKS     = 16,
   parameter int THRESH       = 8,
   parameter int IDLE_NIBBLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                mod_in,
   output logic [NIBBLE_W-1:0] data_out,
   output logic                data_available,
   output logic                active
);

   localparam int IDX_W = $clog2(NIBBLE_W);
   localparam int ZC_W  = $clog2(IDLE_NIBBLES + 1);

   logic                r_sync1;
   logic                r_s_in;
   logic                r_s_prev;
   packer_state_t       r_state;
   logic [NIBBLE_W-2:0] r_shreg;
   logic [IDX_W-1:0]    r_bit_idx;
   logic [ZC_W-1:0]     r_zcnt;
   logic [NIBBLE_W-1:0] r_data_out;
   logic                r_data_avail;
   logic                r_active;

   logic                w_start;
   logic                w_count;
   logic                w_bit_valid;
   logic                w_bit_value;
   logic [NIBBLE_W-1:0] w_nibble;
   logic [ZC_W-1:0]     w_zcnt_next;

   // The edge cycle itself is phase 0 of bit 0, so it is counted too.
   assign w_start  = (r_state == ST_IDLE) & enable & r_s_in & ~r_s_prev;
   assign w_count  = enable & ((r_state == ST_RUN) | w_start);
   assign w_nibble = {r_shreg, w_bit_value};

   always_comb begin
      w_zcnt_next = '0;
      if (w_nibble == '0) begin
         w_zcnt_next = (r_zcnt == ZC_W'(IDLE_NIBBLES)) ? r_zcnt : r_zcnt + 1'b1;
      end
   end

   relay_bit_integrator #(
      .BIT_CLKS (BIT_CLKS),
      .THRESH   (THRESH)
   ) u_integrator (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (~enable),
      .i_count     (w_count),
      .i_sample    (r_s_in),
      .o_bit_valid (w_bit_valid),
      .o_bit_value (w_bit_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_s_in   <= 1'b0;
         r_s_prev <= 1'b0;
      end else begin
         r_sync1  <= mod_in;
         r_s_in   <= r_sync1;
         r_s_prev <= r_s_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_bit_idx    <= '0;
         r_zcnt       <= '0;
         r_data_out   <= '0;
         r_data_avail <= 1'b0;
         r_active     <= 1'b0;
      end else begin
         r_data_avail <= 1'b0;
         // Follows the state, except it stays high through the cycle in which
         // the final zero nibble is strobed and falls one edge later.
         r_active     <= enable & ((r_state == ST_RUN) | w_start);
         if (!enable) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_zcnt    <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state   <= ST_RUN;
                     r_shreg   <= '0;
                     r_bit_idx <= '0;
                     r_zcnt    <= '0;
                  end
               end
               ST_RUN: begin
                  if (w_bit_valid) begin
                     r_shreg   <= w_nibble[NIBBLE_W-2:0];
                     r_bit_idx <= r_bit_idx + 1'b1;
                     if (r_bit_idx == IDX_W'(NIBBLE_W - 1)) begin
                        r_data_out   <= w_nibble;
                        r_data_avail <= 1'b1;
                        r_zcnt       <= w_zcnt_next;
                        if (w_zcnt_next == ZC_W'(IDLE_NIBBLES)) begin
                           r_state <= ST_IDLE;
                        end
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign data_out       = r_data_out;
   assign data_available = r_data_avail;
   assign active         = r_active;

endmodule
